// File: rtl/bouncing_square_ctrl.sv
// Command generator for the DrawSquare stage: clears the LCD once after reset, then on each
// frame tick erases the square, steps it with edge bounce and redraws it, one command at a time.
module bouncing_square_ctrl #(
  parameter int          CLOCK_FREQ = 50000000,
  parameter int          FRAME_HZ   = 50,
  parameter int          LCD_WIDTH  = 240,
  parameter int          LCD_HEIGHT = 320,
  parameter int          SQ_W       = 20,
  parameter int          SQ_H       = 20,
  parameter int          STEP_X     = 2,
  parameter int          STEP_Y     = 3,
  parameter logic [15:0] FG_COLOUR  = 16'hF800,
  parameter logic [15:0] BG_COLOUR  = 16'h0000
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        enable,
  input  logic        drawReady,
  output logic        draw,
  output logic [7:0]  xOrigin,
  output logic [8:0]  yOrigin,
  output logic [7:0]  width,
  output logic [8:0]  height,
  output logic [15:0] pixelData,
  output logic        busy,
  output logic [7:0]  moveCount
);

  localparam int            TICK_DIV  = CLOCK_FREQ / FRAME_HZ;
  localparam int            PW        = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [PW-1:0] TICK_LAST = PW'(TICK_DIV - 1);
  localparam logic [9:0]    XMAX      = 10'(LCD_WIDTH - SQ_W);
  localparam logic [9:0]    YMAX      = 10'(LCD_HEIGHT - SQ_H);
  localparam logic [9:0]    STEP_X10  = 10'(STEP_X);
  localparam logic [9:0]    STEP_Y10  = 10'(STEP_Y);

  typedef enum logic [2:0] {INIT, WAIT_TICK, ERASE, STEP, DRAW} main_t;
  typedef enum logic [1:0] {CMD_ARM, CMD_ASSERT, CMD_RELEASE} cmd_t;
  typedef enum logic {DIR_POS, DIR_NEG} dir_t;

  main_t main, main_next;
  cmd_t  cmd, cmd_next;
  logic  cmd_active, cmd_done, consume;

  logic [PW-1:0] presc;
  logic          tick, tick_pending;

  logic [7:0] pos_x, pos_x_next;
  logic [8:0] pos_y, pos_y_next;
  dir_t       dir_x, dir_x_next, dir_y, dir_y_next;
  logic [9:0] x_sum, y_sum;

  logic [7:0]  cmd_x, cmd_w;
  logic [8:0]  cmd_y, cmd_h;
  logic [15:0] cmd_colour;

  // Frame tick prescaler and single-slot pending flag; a fresh tick wins over a same-cycle consume.
  assign tick = (presc == TICK_LAST);

  // NOTE: every clocked process uses non-blocking assignments so all registers update together.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      presc        <= '0;
      tick_pending <= 1'b0;
    end else begin
      presc        <= tick ? '0 : presc + 1'b1;
      tick_pending <= tick | (tick_pending & ~consume);
    end
  end

  assign cmd_active = (main == INIT) || (main == ERASE) || (main == DRAW);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      main <= INIT;
      cmd  <= CMD_ARM;
    end else begin
      main <= main_next;
      cmd  <= cmd_next;
    end
  end

  // NOTE: defaults first in every always_comb so no path leaves a signal unassigned (no latches).
  always_comb begin
    main_next = main;
    cmd_next  = cmd;
    cmd_done  = 1'b0;
    consume   = 1'b0;
    if (cmd_active) begin
      unique case (cmd)
        CMD_ARM:     if (drawReady)  cmd_next = CMD_ASSERT;
        CMD_ASSERT:  if (!drawReady) cmd_next = CMD_RELEASE;
        CMD_RELEASE: if (drawReady) begin
          cmd_next = CMD_ARM;
          cmd_done = 1'b1;
        end
        default:     cmd_next = CMD_ARM;
      endcase
    end
    case (main)
      INIT:      if (cmd_done) main_next = WAIT_TICK;
      WAIT_TICK: if (tick_pending && enable) begin
        consume   = 1'b1;
        main_next = ERASE;
      end
      ERASE:     if (cmd_done) main_next = STEP;
      STEP:      main_next = DRAW;
      DRAW:      if (cmd_done) main_next = WAIT_TICK;
      default:   main_next = INIT;
    endcase
  end

  always_comb begin
    cmd_x      = '0;
    cmd_y      = '0;
    cmd_w      = 8'(LCD_WIDTH);
    cmd_h      = 9'(LCD_HEIGHT);
    cmd_colour = BG_COLOUR;
    if (main != INIT) begin
      cmd_x      = pos_x;
      cmd_y      = pos_y;
      cmd_w      = 8'(SQ_W);
      cmd_h      = 9'(SQ_H);
      cmd_colour = (main == DRAW) ? FG_COLOUR : BG_COLOUR;
    end
  end

  // Payload is reloaded only while arming, so it stays frozen while DrawSquare is reading it.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      xOrigin   <= '0;
      yOrigin   <= '0;
      width     <= '0;
      height    <= '0;
      pixelData <= '0;
    end else if (cmd_active && cmd == CMD_ARM) begin
      xOrigin   <= cmd_x;
      yOrigin   <= cmd_y;
      width     <= cmd_w;
      height    <= cmd_h;
      pixelData <= cmd_colour;
    end
  end

  assign draw = cmd_active && (cmd == CMD_ASSERT);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      busy      <= 1'b0;
      moveCount <= '0;
    end else begin
      busy <= (main_next != WAIT_TICK);
      if (main == DRAW && cmd_done) moveCount <= moveCount + 8'd1;
    end
  end

  // Bounce arithmetic in 10 bits so the sum cannot wrap before the edge compare.
  assign x_sum = {2'b00, pos_x} + STEP_X10;
  assign y_sum = {1'b0, pos_y} + STEP_Y10;

  always_comb begin
    pos_x_next = pos_x;
    dir_x_next = dir_x;
    pos_y_next = pos_y;
    dir_y_next = dir_y;
    if (dir_x == DIR_POS) begin
      if (x_sum >= XMAX) begin
        pos_x_next = XMAX[7:0];
        dir_x_next = DIR_NEG;
      end else begin
        pos_x_next = x_sum[7:0];
      end
    end else if ({2'b00, pos_x} <= STEP_X10) begin
      pos_x_next = '0;
      dir_x_next = DIR_POS;
    end else begin
      pos_x_next = pos_x - STEP_X10[7:0];
    end
    if (dir_y == DIR_POS) begin
      if (y_sum >= YMAX) begin
        pos_y_next = YMAX[8:0];
        dir_y_next = DIR_NEG;
      end else begin
        pos_y_next = y_sum[8:0];
      end
    end else if ({1'b0, pos_y} <= STEP_Y10) begin
      pos_y_next = '0;
      dir_y_next = DIR_POS;
    end else begin
      pos_y_next = pos_y - STEP_Y10[8:0];
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      pos_x <= '0;
      pos_y <= '0;
      dir_x <= DIR_POS;
      dir_y <= DIR_POS;
    end else if (main == STEP) begin
      pos_x <= pos_x_next;
      pos_y <= pos_y_next;
      dir_x <= dir_x_next;
      dir_y <= dir_y_next;
    end
  end

endmodule
